// File: rtl/fpcvt_seq.sv
// fpcvt_seq: sequential linear-to-floating-point converter.
// Takes a DW-bit two's-complement sample, normalises its magnitude one bit
// per cycle, then rounds (half up) or truncates into sign / EW-bit exponent /
// FW-bit significand, saturating to the largest code on exponent overflow.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE
// and the result holds there until out_ready is seen.
module fpcvt_seq #(
  parameter int DW = 13,
  parameter int EW = 3,
  parameter int FW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          round_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_s,
  output logic [EW-1:0] out_e,
  output logic [FW-1:0] out_f,
  output logic [1:0]    dbg_state
);

  localparam int M     = DW - 1;          // magnitude bits
  localparam int SHMAX = M - FW;          // starting exponent / max shifts
  localparam int CW    = $clog2(SHMAX + 2); // room for SHMAX+1 after round carry
  localparam int EMAX  = (2 ** EW) - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [M-1:0]  mag;
  logic [CW-1:0] e_cnt;
  logic          s_q;
  logic          rnd_q;

  logic [DW-1:0] neg_data;
  logic [M-1:0]  in_mag;
  logic [FW-1:0] f_trunc;
  logic          r_bit;
  logic [FW-1:0] f_rnd;
  logic [CW-1:0] e_rnd;
  logic          sat;

  assign dbg_state = state;
  assign neg_data  = ~in_data + {{(DW-1){1'b0}}, 1'b1};

  // Magnitude of the incoming sample; the most-negative code has no
  // positive counterpart in M bits, so it clamps to all ones.
  always_comb begin
    in_mag = in_data[M-1:0];
    if (in_data[DW-1]) begin
      if (in_data[M-1:0] == '0) in_mag = '1;
      else                      in_mag = neg_data[M-1:0];
    end
  end

  assign f_trunc = mag[M-1 -: FW];
  assign r_bit   = mag[M-FW-1] & rnd_q;

  // Round the normalised magnitude; a carry out of an all-ones significand
  // renormalises to 1.000.. and bumps the exponent, which may then saturate.
  always_comb begin
    f_rnd = f_trunc + {{(FW-1){1'b0}}, r_bit};
    e_rnd = e_cnt;
    if (r_bit && (&f_trunc)) begin
      f_rnd = {1'b1, {(FW-1){1'b0}}};
      e_rnd = e_cnt + {{(CW-1){1'b0}}, 1'b1};
    end
    sat = (int'(e_rnd) > EMAX);
  end

  // Control FSM with registered handshake flags and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_s     <= 1'b0;
      out_e     <= '0;
      out_f     <= '0;
      mag       <= '0;
      e_cnt     <= '0;
      s_q       <= 1'b0;
      rnd_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            s_q      <= in_data[DW-1];
            rnd_q    <= round_en;
            mag      <= in_mag;
            e_cnt    <= CW'(SHMAX);
            in_ready <= 1'b0;
            state    <= NORM;
          end
        end
        NORM: begin
          if (mag[M-1] || (e_cnt == '0)) begin
            state <= ROUND;
          end else begin
            mag   <= {mag[M-2:0], 1'b0};
            e_cnt <= e_cnt - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        ROUND: begin
          out_s     <= s_q;
          out_e     <= sat ? EW'(EMAX) : EW'(e_rnd);
          out_f     <= sat ? {FW{1'b1}} : f_rnd;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpcvt_seq.sv
// Testbench for fpcvt_seq with default parameters (DW=13, EW=3, FW=5).
module tb_fpcvt_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_data;
  logic        round_en;
  logic        out_valid;
  logic        out_ready;
  logic        out_s;
  logic [2:0]  out_e;
  logic [4:0]  out_f;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  fpcvt_seq #(.DW(13), .EW(3), .FW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .round_en(round_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_e(out_e), .out_f(out_f),
    .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // Reference: value = F * 2^E with F < 32; pick the smallest E that fits
  // the magnitude, round on the first dropped bit, then renormalise/saturate.
  function automatic void model(input logic [12:0] d, input logic r,
                                output logic s, output logic [2:0] e_o,
                                output logic [4:0] f_o, output int lat);
    int v, mag, e, f, p, sh;
    v = $signed(d);
    s = (v < 0);
    mag = (v < 0) ? -v : v;
    if (mag > 4095) mag = 4095;
    e = 0;
    while (mag >= (32 << e)) e++;
    f = mag >> e;
    if (r && e > 0 && (((mag >> (e - 1)) & 1) == 1)) f++;
    if (f == 32) begin f = 16; e++; end
    if (e > 7) begin e = 7; f = 31; end
    e_o = 3'(e);
    f_o = 5'(f);
    p = -1;
    for (int b = 0; b < 12; b++) if (((mag >> b) & 1) == 1) p = b;
    sh = 11 - p;
    if (sh > 7) sh = 7;
    lat = sh + 2;
  endfunction

  // Driver: called at a negedge. Sends one sample, measures latency (edges
  // after accept until out_valid is seen), then drains with random stalls,
  // noting whether outputs held steady. lat = -1 on timeout.
  task automatic conv(input logic [12:0] d, input logic r, input int stall_pct,
                      output logic s, output logic [2:0] e, output logic [4:0] f,
                      output int lat, output logic held);
    int n, k;
    logic go;
    held = 1'b1; lat = -1; s = 1'b0; e = '0; f = '0;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    in_valid = 1'b1; in_data = d; round_en = r;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_data = 13'($urandom); round_en = 1'($urandom);
    k = 0;
    while (!out_valid && k < 50) begin @(negedge clk); k++; end
    if (!out_valid) begin held = 1'b0; return; end
    lat = k; s = out_s; e = out_e; f = out_f;
    n = 0; go = 1'b0;
    while (!go && n < 200) begin
      out_ready = ($urandom_range(0, 99) >= stall_pct);
      go = out_ready;
      @(negedge clk);
      if (!go && (!out_valid || in_ready || out_s !== s || out_e !== e || out_f !== f))
        held = 1'b0;
      n++;
    end
    out_ready = 1'b0;
    if (!go || out_valid !== 1'b0 || in_ready !== 1'b1) held = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; round_en = 1'b1; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if ({out_s, out_e, out_f} !== 9'd0) begin errors++; $display("FAIL reset_outputs got=%b/%0d/%0d exp=0/0/0", out_s, out_e, out_f); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [12:0] dv [11] = '{13'd0, 13'd63, 13'd63, -13'sd33, 13'd4095, -13'sd4096,
                             13'd3967, 13'd31, -13'sd8, 13'd32, 13'd100};
    logic        rv [11] = '{1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    logic [8:0]  xv [11] = '{{1'b0, 3'd0, 5'd0},  {1'b0, 3'd2, 5'd16}, {1'b0, 3'd1, 5'd31},
                             {1'b1, 3'd1, 5'd17}, {1'b0, 3'd7, 5'd31}, {1'b1, 3'd7, 5'd31},
                             {1'b0, 3'd7, 5'd31}, {1'b0, 3'd0, 5'd31}, {1'b1, 3'd0, 5'd8},
                             {1'b0, 3'd1, 5'd16}, {1'b0, 3'd2, 5'd25}};
    int          lv [11] = '{9, 8, 8, 8, 2, 2, 2, 9, 9, 8, 7};
    logic s; logic [2:0] e; logic [4:0] f; int lat; logic held;
    for (int i = 0; i < 11; i++) begin
      conv(dv[i], rv[i], 0, s, e, f, lat, held);
      checks++;
      if ({s, e, f} !== xv[i]) begin
        errors++;
        $display("FAIL directed_result in=%0d rnd=%b got=%b/%0d/%0d exp=%b/%0d/%0d",
                 $signed(dv[i]), rv[i], s, e, f, xv[i][8], xv[i][7:5], xv[i][4:0]);
      end
      checks++;
      if (lat !== lv[i]) begin
        errors++;
        $display("FAIL directed_latency in=%0d got=%0d exp=%0d", $signed(dv[i]), lat, lv[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic s, xs, s2, held; logic [2:0] e, xe, e2; logic [4:0] f, xf, f2; int lat, xl, k;
    logic [12:0] d2;
    while (!in_ready) @(negedge clk);
    in_valid = 1'b1; in_data = 13'd1000; round_en = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 50) begin @(negedge clk); k++; end
    model(13'd1000, 1'b1, xs, xe, xf, xl);
    checks++;
    if (!out_valid || {out_s, out_e, out_f} !== {xs, xe, xf}) begin
      errors++;
      $display("FAIL bp_result valid=%b got=%b/%0d/%0d exp=%b/%0d/%0d", out_valid, out_s, out_e, out_f, xs, xe, xf);
    end
    s = out_s; e = out_e; f = out_f;
    // stall for 5 cycles while offering a new sample that must be ignored
    in_valid = 1'b1; in_data = 13'($urandom); round_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_s, out_e, out_f} !== {s, e, f}) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d valid=%b ready=%b got=%b/%0d/%0d exp=1/0/%b/%0d/%0d",
                 i, out_valid, in_ready, out_s, out_e, out_f, s, e, f);
      end
    end
    // release with in_valid still high: DONE must not accept it
    d2 = 13'($urandom); in_data = d2; round_en = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
    conv(d2, 1'b1, 0, s2, e2, f2, lat, held);
    model(d2, 1'b1, xs, xe, xf, xl);
    checks++;
    if ({s2, e2, f2} !== {xs, xe, xf} || lat !== xl) begin
      errors++;
      $display("FAIL bp_back_to_back in=%0d got=%b/%0d/%0d lat=%0d exp=%b/%0d/%0d lat=%0d",
               $signed(d2), s2, e2, f2, lat, xs, xe, xf, xl);
    end
  endtask

  task automatic test_reset_mid();
    logic s, held; logic [2:0] e; logic [4:0] f; int lat;
    int seen;
    while (!in_ready) @(negedge clk);
    in_valid = 1'b1; in_data = 13'd1; round_en = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || {out_s, out_e, out_f} !== 9'd0) begin
      errors++;
      $display("FAIL reset_mid valid=%b ready=%b out=%b/%0d/%0d exp 0/1/0/0/0", out_valid, in_ready, out_s, out_e, out_f);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (out_valid) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL reset_mid_no_result got=%0d valid cycles exp=0", seen); end
    conv(13'd100, 1'b1, 0, s, e, f, lat, held);
    checks++;
    if ({s, e, f} !== {1'b0, 3'd2, 5'd25} || lat !== 7) begin
      errors++;
      $display("FAIL reset_mid_next got=%b/%0d/%0d lat=%0d exp=0/2/25 lat=7", s, e, f, lat);
    end
  endtask

  task automatic test_sweep();
    logic s, xs, held; logic [2:0] e, xe; logic [4:0] f, xf; int lat, xl;
    logic [12:0] d; logic r;
    for (int i = 0; i < 8192 + 1500; i++) begin
      if (i < 8192) begin d = 13'(i); r = 1'b1; end
      else begin d = 13'($urandom); r = 1'b0; end
      conv(d, r, 20, s, e, f, lat, held);
      model(d, r, xs, xe, xf, xl);
      checks++;
      if ({s, e, f} !== {xs, xe, xf}) begin
        errors++;
        $display("FAIL sweep_result in=%0d rnd=%b got=%b/%0d/%0d exp=%b/%0d/%0d", $signed(d), r, s, e, f, xs, xe, xf);
      end
      checks++;
      if (lat !== xl) begin
        errors++;
        $display("FAIL sweep_latency in=%0d got=%0d exp=%0d", $signed(d), lat, xl);
      end
      checks++;
      if (held !== 1'b1) begin
        errors++;
        $display("FAIL sweep_hold in=%0d got=%b exp=1", $signed(d), held);
      end
      if (lat < 0) break;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
